// File: rtl/ram512_defs.sv
// Shared widths and FSM state encoding for the ram512 block-copy engine and its RAM.
package ram512_defs;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/ram512.sv
// 512-word RAM: synchronous write on load, combinational read of address.
module ram512 #(
  parameter int DATA_W = ram512_defs::DATA_W,
  parameter int ADDR_W = ram512_defs::ADDR_W
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (load) mem_q[address] <= in;
  end

  assign out = mem_q[address];
endmodule

// File: rtl/ram512_copier.sv
// Block-copy engine for ram512: copies len words src->dst, ascending, two cycles per word.
// Optional RAM512_COPIER_FILL_EN adds fill/pattern inputs for a one-cycle-per-word memset.
module ram512_copier #(
  parameter int DATA_W = ram512_defs::DATA_W,
  parameter int ADDR_W = ram512_defs::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
`ifdef RAM512_COPIER_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  import ram512_defs::*;

  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] data_q;
  logic              fill_q;
  logic              start_fill;
  logic [DATA_W-1:0] start_data;

`ifdef RAM512_COPIER_FILL_EN
  assign start_fill = fill;
  assign start_data = pattern;
`else
  assign start_fill = 1'b0;
  assign start_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)      state_d = ST_DONE;
          else if (start_fill) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (count_q == CNT_W'(1)) state_d = ST_DONE;
        else if (fill_q)          state_d = ST_WRITE;
        else                      state_d = ST_READ;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // In fill mode the pattern is parked in data_q, so ram_in is always data_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q   <= src;
            dst_q   <= dst;
            count_q <= len;
            fill_q  <= start_fill;
            if (start_fill) data_q <= start_data;
          end
        end
        ST_READ: data_q <= ram_out;
        ST_WRITE: begin
          src_q   <= src_q + ADDR_W'(1);
          dst_q   <= dst_q + ADDR_W'(1);
          count_q <= count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = data_q;
    case (state_q)
      ST_READ: begin
        busy        = 1'b1;
        ram_address = src_q;
      end
      ST_WRITE: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = dst_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram512_copier.sv
// Bench for ram512_copier wired to ram512; bench-side mux gives direct RAM access for preload/readback.
module tb_ram512_copier;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  src = '0, dst = '0;
  logic [9:0]  len = '0;
  logic        busy, done, cp_load;
  logic [8:0]  cp_addr;
  logic [15:0] cp_in, ram_out;
`ifdef RAM512_COPIER_FILL_EN
  logic        fill = 1'b0;
  logic [15:0] pattern = '0;
`endif

  logic        tb_sel = 1'b1, tb_load = 1'b0;
  logic [8:0]  tb_addr = '0;
  logic [15:0] tb_din = '0;
  logic [8:0]  r_addr;
  logic [15:0] r_in;
  logic        r_load;

  assign r_addr = tb_sel ? tb_addr : cp_addr;
  assign r_in   = tb_sel ? tb_din  : cp_in;
  assign r_load = tb_sel ? tb_load : cp_load;

  always #5 clk = ~clk;

  ram512_copier dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef RAM512_COPIER_FILL_EN
    .fill(fill), .pattern(pattern),
`endif
    .busy(busy), .done(done), .ram_address(cp_addr), .ram_in(cp_in),
    .ram_load(cp_load), .ram_out(ram_out)
  );

  ram512 u_ram (.clk(clk), .in(r_in), .address(r_addr), .load(r_load), .out(ram_out));

  typedef struct { logic [8:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] model [0:511];
  int          n_checks = 0;
  int          n_fail = 0;

  // Scoreboard: every copier write is checked against the next expected write.
  always @(negedge clk) begin
    if (cp_load === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", cp_addr, cp_in);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (cp_addr !== e.a || cp_in !== e.d) begin
          n_fail++;
          $display("FAIL write addr/data got %0d/%h expected %0d/%h", cp_addr, cp_in, e.a, e.d);
        end else
          $display("write ok addr=%0d data=%h", cp_addr, cp_in);
      end
    end
  end

  task automatic ram_write(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_sel = 1'b1; tb_addr = a; tb_din = d; tb_load = 1'b1;
    @(posedge clk); #1;
    tb_load = 1'b0;
    model[a] = d;
  endtask

  task automatic check_mem(input string name);
    int mism = 0;
    int first = -1;
    logic [15:0] got = '0;
    @(negedge clk);
    tb_sel = 1'b1; tb_load = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tb_addr = 9'(i); #1;
      if (ram_out !== model[i]) begin
        if (first < 0) begin first = i; got = ram_out; end
        mism++;
      end
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL %s mem: %0d words differ, first addr=%0d got %h expected %h",
               name, mism, first, got, model[first]);
    end else
      $display("%s mem: contents ok", name);
  endtask

  task automatic run_copy(input string name, input logic [8:0] s, input logic [8:0] d,
                          input logic [9:0] n, input bit f, input logic [15:0] pat,
                          input int repulse_cyc, input int reset_cyc);
    int nw, busy_cnt, done_cyc, exp_busy, limit;
    nw = int'(n);
    if (reset_cyc > 0 && (reset_cyc - 1) / 2 < nw) nw = (reset_cyc - 1) / 2;
    for (int i = 0; i < nw; i++) begin
      wr_t w;
      w.a = 9'(int'(d) + i);
      w.d = f ? pat : model[9'(int'(s) + i)];
      model[w.a] = w.d;
      exp_q.push_back(w);
    end
    exp_busy = f ? int'(n) : 2 * int'(n);
    limit = exp_busy + 4;
    busy_cnt = 0; done_cyc = 0;

    @(negedge clk);
    tb_sel = 1'b0; src = s; dst = d; len = n; start = 1'b1;
`ifdef RAM512_COPIER_FILL_EN
    fill = f; pattern = pat;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == repulse_cyc) begin start = 1'b1; src = 9'd0; dst = 9'd1; len = 10'd1; end
      if (c == repulse_cyc + 1) start = 1'b0;
      if (reset_cyc > 0 && c == reset_cyc + 1) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cp_load !== 1'b0 || cp_addr !== 9'd0) begin
          n_fail++;
          $display("FAIL %s after_reset busy/done/load/addr got %b/%b/%b/%0d expected 0/0/0/0",
                   name, busy, done, cp_load, cp_addr);
        end
        reset = 1'b0;
        break;
      end
      if (reset_cyc > 0 && c == reset_cyc) reset = 1'b1;
      if (done_cyc != 0 && c == done_cyc + 1) begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_width done/busy got %b/%b expected 0/0", name, done, busy);
        end
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
    end
    if (reset_cyc == 0) begin
      n_checks++;
      if (busy_cnt != exp_busy) begin
        n_fail++;
        $display("FAIL %s busy_cycles got %0d expected %0d", name, busy_cnt, exp_busy);
      end
      n_checks++;
      if (done_cyc != exp_busy + 1) begin
        n_fail++;
        $display("FAIL %s done_cycle got %0d expected %0d (0 = timeout)", name, done_cyc, exp_busy + 1);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_writes got %0d outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    $display("%s: src=%0d dst=%0d len=%0d busy=%0d done_cyc=%0d", name, s, d, n, busy_cnt, done_cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cp_load !== 1'b0 || cp_addr !== 9'd0 || cp_in !== 16'd0) begin
      n_fail++;
      $display("FAIL reset busy/done/load/addr/in got %b/%b/%b/%0d/%h expected 0/0/0/0/0000",
               busy, done, cp_load, cp_addr, cp_in);
    end else
      $display("reset: outputs idle");
    reset = 1'b0;
    for (int i = 0; i < 512; i++) ram_write(9'(i), 16'(i * 37 + 16'h0500));
  endtask

  task automatic test_basic();
    ram_write(9'd10, 16'd1); ram_write(9'd11, 16'd2);
    ram_write(9'd12, 16'd3); ram_write(9'd13, 16'd4);
    run_copy("basic", 9'd10, 9'd100, 10'd4, 1'b0, 16'h0, 0, 0);
    check_mem("basic");
  endtask

  task automatic test_len0();
    run_copy("len0", 9'd5, 9'd6, 10'd0, 1'b0, 16'h0, 0, 0);
    check_mem("len0");
  endtask

  task automatic test_wrap();
    ram_write(9'd510, 16'hAAAA); ram_write(9'd511, 16'hBBBB); ram_write(9'd0, 16'hCCCC);
    run_copy("wrap", 9'd510, 9'd200, 10'd3, 1'b0, 16'h0, 0, 0);
    check_mem("wrap");
  endtask

  task automatic test_overlap();
    ram_write(9'd20, 16'd7); ram_write(9'd21, 16'd8); ram_write(9'd22, 16'd9);
    run_copy("overlap", 9'd20, 9'd21, 10'd2, 1'b0, 16'h0, 0, 0);
    run_copy("same", 9'd20, 9'd20, 10'd3, 1'b0, 16'h0, 0, 0);
    check_mem("overlap");
  endtask

  task automatic test_restart_and_abort();
    run_copy("repulse", 9'd30, 9'd40, 10'd4, 1'b0, 16'h0, 3, 0);
    run_copy("reset_mid", 9'd50, 9'd60, 10'd4, 1'b0, 16'h0, 0, 5);
    check_mem("restart_abort");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      run_copy("b2b", 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
               10'($urandom_range(1, 6)), 1'b0, 16'h0, 0, 0);
    run_copy("full", 9'd0, 9'd0, 10'd512, 1'b0, 16'h0, 0, 0);
    check_mem("back_to_back");
  endtask

`ifdef RAM512_COPIER_FILL_EN
  task automatic test_fill();
    run_copy("fill", 9'd0, 9'd300, 10'd5, 1'b1, 16'h1234, 0, 0);
    run_copy("after_fill", 9'd300, 9'd400, 10'd2, 1'b0, 16'h0, 0, 0);
    check_mem("fill");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_overlap();
    test_restart_and_abort();
    test_back_to_back();
`ifdef RAM512_COPIER_FILL_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram512_copier.md
Name: ram512_copier

Overview:
Block-copy DMA engine that sits directly upstream of ram512 and drives its in/address/load port, reading back through its out port.
Copies len 16-bit words from a source region to a destination region of the 512-word RAM, one word per two cycles.
Frees the CPU/testbench from sequencing individual RAM accesses; it is started and monitored with a start/busy/done handshake.

Parameters:
DATA_W, 16, word width; matches ram512 data width.
ADDR_W, 9, address width; 512 words.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
src  input  ADDR_W  source base address; sampled with start.
dst  input  ADDR_W  destination base address; sampled with start.
len  input  ADDR_W+1  word count, 0..512; sampled with start.
busy  output  1  high in READ and WRITE.
done  output  1  one-cycle pulse in DONE.
ram_address  output  ADDR_W  to ram512 address.
ram_in  output  DATA_W  to ram512 in.
ram_load  output  1  to ram512 load.
ram_out  input  DATA_W  from ram512 out; combinational read of ram_address.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, ram_load=0, ram_address=0, ram_in=0, internal src_ptr/dst_ptr/count/data_reg=0.
- Reset mid-copy: abort on the next edge and return to IDLE. No further ram_load. Words already written stay written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - ram_load=0 and ram_address=0.
  - On start=1, latch src→src_ptr, dst→dst_ptr, len→count.
  - If len==0, go to DONE; otherwise go to READ.
- READ:
  - Drive ram_address=src_ptr and ram_load=0.
  - At the edge, capture ram_out→data_reg and go to WRITE.
- WRITE:
  - Drive ram_address=dst_ptr, ram_in=data_reg, ram_load=1.
  - At the edge: src_ptr+1, dst_ptr+1, count-1.
  - If count==1, go to DONE; else go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- ram_in holds data_reg in all states; only ram_load qualifies it.
- Latency: with start sampled at edge 0, there are 2*len busy cycles. done is high in cycle 2*len+1. For len=0, done is high in cycle 1.
- Start while busy or in DONE: ignored. No queuing and no restart.
- Wrap-around: pointers are ADDR_W bits and wrap 511→0 silently.
  - len=512 copies the whole memory; count needs ADDR_W+1 bits.
- Overlap: copy is strictly ascending, word by word.
  - dst>src with overlap propagates already-copied data (memmove is NOT guaranteed).
  - src==dst rewrites each word with itself.
- Outputs are decoded combinationally from the registered state and pointers. No combinational path from start to ram_*.

Optional Feature:
Macro RAM512_COPIER_FILL_EN.
- Defined:
  - Adds input fill (1) and input pattern (DATA_W), both sampled with start.
  - When fill=1, READ is skipped: IDLE→WRITE, and WRITE→WRITE until count==1.
  - ram_in=pattern, at 1 cycle per word; src is ignored. done then appears in cycle len+1.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Shared package/header ram512_defs: DATA_W, ADDR_W, state encoding constants (IDLE=0, READ=1, WRITE=2, DONE=3).
- No sub-module is needed. The FSM plus pointer/count datapath is a single module.
- The bench instantiates ram512_copier and ram512 together, with ram_* wired to ram512's in/address/load/out.

Test Plan:
- Preload RAM[10..13]=1,2,3,4; start src=10, dst=100, len=4 → busy for 8 cycles, done in cycle 9, RAM[100..103]=1,2,3,4, RAM[10..13] unchanged.
- len=0, src=5, dst=6 → busy never asserted, done in cycle 1, no ram_load pulse, RAM unchanged.
- Wrap: RAM[510]=0xAAAA, RAM[511]=0xBBBB, RAM[0]=0xCCCC; src=510, dst=200, len=3 → RAM[200..202]=0xAAAA,0xBBBB,0xCCCC.
- Overlap: RAM[20..22]=7,8,9; src=20, dst=21, len=2 → RAM[21]=7, RAM[22]=7 (ascending propagation).
- Start re-pulsed at cycle 3 of a len=4 copy, and reset asserted at cycle 5 of a second copy:
  - The re-pulse is ignored; first copy completes unchanged.
  - On reset, state is IDLE next cycle, ram_load=0, only the words written before the reset are changed.
- With RAM512_COPIER_FILL_EN: fill=1, pattern=0x1234, dst=300, len=5 → RAM[300..304]=0x1234, busy for 5 cycles, done in cycle 6.
